micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 161 ++++++++++++++++
 tb/tb_micro_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: decodes the branch field of the current microinstruction
// and drives a registered next-address request with a 4-deep return stack.
module micro_sequencer #(
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [10:0] PC,
    input  logic [2:0]  branchType,
    input  logic [10:0] branchAdd,
    input  logic [3:0]  flags,
    input  logic [1:0]  condSel,
    input  logic        condPol,
    input  logic        stall,
    input  logic        resume,
    output logic        inc,
    output logic [10:0] nextAdd,
    output logic        preLoad,
    output logic        blockingPC,
    output logic        halted,
    output logic        stackErr,
    output logic [2:0]  depth
);

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [2:0] BR_NEXT     = 3'b000;
    localparam logic [2:0] BR_JMP      = 3'b001;
    localparam logic [2:0] BR_JCOND    = 3'b010;
    localparam logic [2:0] BR_SKIPCOND = 3'b011;
    localparam logic [2:0] BR_CALL     = 3'b100;
    localparam logic [2:0] BR_RET      = 3'b101;
    localparam logic [2:0] BR_HALT     = 3'b110;

    localparam logic [2:0] STACK_FULL = 3'd4;

    logic [2:0]  state;
    logic [10:0] stack_mem [4];
    logic [10:0] pc_plus1;
    logic [10:0] stack_top;
    logic        cond;

    // Wraps at 11 bits, so a CALL from 11'h7FF returns to 11'h000.
    assign pc_plus1  = PC + 11'd1;
    assign stack_top = stack_mem[depth[1:0] - 2'd1];
    assign cond      = flags[condSel] ^ condPol;

    // NOTE: every register here, including the stack entries, is updated with
    // non-blocking assignments so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= ST_BOOT;
            inc        <= 1'b0;
            nextAdd    <= 11'h000;
            preLoad    <= 1'b0;
            blockingPC <= 1'b0;
            halted     <= 1'b0;
            stackErr   <= 1'b0;
            depth      <= 3'd0;
            // NOTE: the stack storage is reset too, so nothing pushed before a
            // reset can ever be popped afterwards.
            for (int i = 0; i < 4; i++) begin
                stack_mem[i] <= 11'h000;
            end
        end else begin
            inc <= 1'b0;
            case (state)
                ST_BOOT: begin
                    nextAdd    <= RESET_VECTOR;
                    blockingPC <= 1'b1;
                    preLoad    <= 1'b0;
                    inc        <= 1'b1;
                    state      <= ST_ISSUE;
                end

                ST_ISSUE:  state <= ST_SETTLE;
                ST_SETTLE: state <= ST_DECODE;

                ST_DECODE: begin
                    if (!stall) begin
                        // Default path is an ISSUE; error and HALT arms override it.
                        inc   <= 1'b1;
                        state <= ST_ISSUE;
                        case (branchType)
                            BR_JMP: begin
                                blockingPC <= 1'b1;
                                preLoad    <= 1'b0;
                                nextAdd    <= branchAdd;
                            end
                            BR_JCOND: begin
                                blockingPC <= cond;
                                preLoad    <= 1'b0;
                                nextAdd    <= cond ? branchAdd : pc_plus1;
                            end
                            BR_SKIPCOND: begin
                                blockingPC <= 1'b0;
                                preLoad    <= cond;
                                nextAdd    <= pc_plus1;
                            end
                            BR_CALL: begin
                                if (depth == STACK_FULL) begin
                                    inc      <= 1'b0;
                                    stackErr <= 1'b1;
                                    halted   <= 1'b1;
                                    state    <= ST_HALT;
                                end else begin
                                    stack_mem[depth[1:0]] <= pc_plus1;
                                    depth      <= depth + 3'd1;
                                    blockingPC <= 1'b1;
                                    preLoad    <= 1'b0;
                                    nextAdd    <= branchAdd;
                                end
                            end
                            BR_RET: begin
                                if (depth == 3'd0) begin
                                    inc      <= 1'b0;
                                    stackErr <= 1'b1;
                                    halted   <= 1'b1;
                                    state    <= ST_HALT;
                                end else begin
                                    depth      <= depth - 3'd1;
                                    blockingPC <= 1'b1;
                                    preLoad    <= 1'b0;
                                    nextAdd    <= stack_top;
                                end
                            end
                            BR_HALT: begin
                                inc    <= 1'b0;
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end
                            default: begin
                                blockingPC <= 1'b0;
                                preLoad    <= 1'b0;
                                nextAdd    <= pc_plus1;
                            end
                        endcase
                    end
                end

                ST_HALT: begin
                    if (resume) begin
                        halted     <= 1'b0;
                        blockingPC <= 1'b0;
                        preLoad    <= 1'b0;
                        nextAdd    <= pc_plus1;
                        inc        <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end

                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: boot, branch decode, return stack,
// stall, halt/resume and reset-during-issue behaviour.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        nReset;
    logic [10:0] PC;
    logic [2:0]  branchType;
    logic [10:0] branchAdd;
    logic [3:0]  flags;
    logic [1:0]  condSel;
    logic        condPol;
    logic        stall;
    logic        resume;
    logic        inc;
    logic [10:0] nextAdd;
    logic        preLoad;
    logic        blockingPC;
    logic        halted;
    logic        stackErr;
    logic [2:0]  depth;

    int checks = 0;
    int errors = 0;

    micro_sequencer #(.RESET_VECTOR(11'h040)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .PC         (PC),
        .branchType (branchType),
        .branchAdd  (branchAdd),
        .flags      (flags),
        .condSel    (condSel),
        .condPol    (condPol),
        .stall      (stall),
        .resume     (resume),
        .inc        (inc),
        .nextAdd    (nextAdd),
        .preLoad    (preLoad),
        .blockingPC (blockingPC),
        .halted     (halted),
        .stackErr   (stackErr),
        .depth      (depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge on which inc is high, bounded.
    task automatic wait_inc(input string tag);
        int n = 0;
        @(negedge clk);
        while (inc !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_inc"}, 32'(inc), 32'd1);
    endtask

    // Watch six negedges and require that no inc pulse appears.
    task automatic expect_no_inc(input string tag);
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (inc === 1'b1) seen++;
        end
        check({tag, "_no_inc"}, 32'(seen), 32'd0);
    endtask

    task automatic set_op(input logic [2:0] bt, input logic [10:0] pc, input logic [10:0] ba);
        branchType = bt;
        PC         = pc;
        branchAdd  = ba;
    endtask

    initial begin
        nReset = 1'b0; PC = 11'h000; branchType = 3'b000; branchAdd = 11'h000;
        flags = 4'b0000; condSel = 2'd0; condPol = 1'b0; stall = 1'b0; resume = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_inc", 32'(inc), 32'd0);
        check("rst_nextAdd", 32'(nextAdd), 32'd0);
        check("rst_preLoad", 32'(preLoad), 32'd0);
        check("rst_blockingPC", 32'(blockingPC), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_stackErr", 32'(stackErr), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);

        // Boot: one inc pulse carrying the reset vector
        nReset = 1'b1;
        @(negedge clk);
        check("boot_inc", 32'(inc), 32'd1);
        check("boot_blockingPC", 32'(blockingPC), 32'd1);
        check("boot_nextAdd", 32'(nextAdd), 32'h040);
        check("boot_preLoad", 32'(preLoad), 32'd0);
        @(negedge clk);
        check("boot_single_pulse", 32'(inc), 32'd0);

        // SKIPCOND taken, then not taken
        set_op(3'b011, 11'h010, 11'h000);
        flags = 4'b0100; condSel = 2'd2; condPol = 1'b0;
        wait_inc("skip_t");
        check("skip_t_preLoad", 32'(preLoad), 32'd1);
        check("skip_t_blockingPC", 32'(blockingPC), 32'd0);
        check("skip_t_nextAdd", 32'(nextAdd), 32'h011);
        condPol = 1'b1;
        wait_inc("skip_n");
        check("skip_n_preLoad", 32'(preLoad), 32'd0);
        check("skip_n_blockingPC", 32'(blockingPC), 32'd0);

        // JMP
        set_op(3'b001, 11'h050, 11'h123);
        wait_inc("jmp");
        check("jmp_blockingPC", 32'(blockingPC), 32'd1);
        check("jmp_nextAdd", 32'(nextAdd), 32'h123);
        check("jmp_preLoad", 32'(preLoad), 32'd0);

        // JCOND taken (flags[1]=0 inverted) then not taken
        set_op(3'b010, 11'h060, 11'h055);
        flags = 4'b0100; condSel = 2'd1; condPol = 1'b1;
        wait_inc("jc_t");
        check("jc_t_blockingPC", 32'(blockingPC), 32'd1);
        check("jc_t_nextAdd", 32'(nextAdd), 32'h055);
        condPol = 1'b0;
        wait_inc("jc_n");
        check("jc_n_blockingPC", 32'(blockingPC), 32'd0);
        check("jc_n_preLoad", 32'(preLoad), 32'd0);

        // CALL then RET
        set_op(3'b100, 11'h020, 11'h100);
        wait_inc("call");
        check("call_nextAdd", 32'(nextAdd), 32'h100);
        check("call_blockingPC", 32'(blockingPC), 32'd1);
        check("call_depth", 32'(depth), 32'd1);
        set_op(3'b101, 11'h100, 11'h000);
        wait_inc("ret");
        check("ret_nextAdd", 32'(nextAdd), 32'h021);
        check("ret_blockingPC", 32'(blockingPC), 32'd1);
        check("ret_depth", 32'(depth), 32'd0);

        // CALL from the top of the address space returns to 0
        set_op(3'b100, 11'h7FF, 11'h200);
        wait_inc("call_wrap");
        check("call_wrap_depth", 32'(depth), 32'd1);
        set_op(3'b101, 11'h200, 11'h000);
        wait_inc("ret_wrap");
        check("ret_wrap_nextAdd", 32'(nextAdd), 32'h000);
        check("ret_wrap_depth", 32'(depth), 32'd0);

        // Stall in DECODE: outputs hold, then ISSUE the cycle after release
        stall = 1'b1;
        set_op(3'b001, 11'h300, 11'h3AA);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_inc", 32'(inc), 32'd0);
            check("stall_nextAdd", 32'(nextAdd), 32'h000);
            check("stall_blockingPC", 32'(blockingPC), 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_inc", 32'(inc), 32'd1);
        check("unstall_nextAdd", 32'(nextAdd), 32'h3AA);

        // HALT op and resume
        set_op(3'b110, 11'h3AA, 11'h000);
        expect_no_inc("halt");
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_stackErr", 32'(stackErr), 32'd0);
        set_op(3'b100, 11'h030, 11'h100);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_inc", 32'(inc), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_blockingPC", 32'(blockingPC), 32'd0);

        // Five CALLs: four push, the fifth overflows into HALT
        for (int i = 1; i <= 4; i++) begin
            wait_inc("call_n");
            check("call_n_depth", 32'(depth), 32'(i));
        end
        expect_no_inc("overflow");
        check("ovf_stackErr", 32'(stackErr), 32'd1);
        check("ovf_halted", 32'(halted), 32'd1);
        check("ovf_depth", 32'(depth), 32'd4);
        set_op(3'b000, 11'h030, 11'h000);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("ovf_resume_inc", 32'(inc), 32'd1);
        check("ovf_resume_blockingPC", 32'(blockingPC), 32'd0);
        check("ovf_resume_halted", 32'(halted), 32'd0);
        check("ovf_resume_stackErr", 32'(stackErr), 32'd1);

        // Pop two entries, then reset in the middle of the following ISSUE
        set_op(3'b101, 11'h100, 11'h000);
        wait_inc("pop1");
        check("pop1_nextAdd", 32'(nextAdd), 32'h031);
        check("pop1_depth", 32'(depth), 32'd3);
        wait_inc("pop2");
        check("pop2_depth", 32'(depth), 32'd2);
        set_op(3'b000, 11'h031, 11'h000);
        wait_inc("pre_rst");
        check("pre_rst_depth", 32'(depth), 32'd2);
        nReset = 1'b0;
        #1;
        check("midrst_inc", 32'(inc), 32'd0);
        check("midrst_depth", 32'(depth), 32'd0);
        check("midrst_stackErr", 32'(stackErr), 32'd0);
        check("midrst_nextAdd", 32'(nextAdd), 32'd0);
        #2;
        nReset = 1'b1;
        @(negedge clk);
        check("reboot_inc", 32'(inc), 32'd1);
        check("reboot_nextAdd", 32'(nextAdd), 32'h040);
        check("reboot_blockingPC", 32'(blockingPC), 32'd1);

        // RET on an empty stack
        set_op(3'b101, 11'h040, 11'h000);
        expect_no_inc("underflow");
        check("unf_stackErr", 32'(stackErr), 32'd1);
        check("unf_halted", 32'(halted), 32'd1);
        check("unf_depth", 32'(depth), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
